// File: rtl/instruction_sequencer_pkg.sv
// rtl/instruction_sequencer_pkg.sv - opcodes, field sizes and FSM encoding shared by the sequencer
package instruction_sequencer_pkg;

   localparam int INSTRUCTION_SIZE = 3;
   localparam int OPERAND_SIZE     = 8;
   localparam int WORD_SIZE        = INSTRUCTION_SIZE + OPERAND_SIZE;

   localparam logic [INSTRUCTION_SIZE-1:0] OP_LOAD    = 3'b000;
   localparam logic [INSTRUCTION_SIZE-1:0] OP_MOV     = 3'b001;
   localparam logic [INSTRUCTION_SIZE-1:0] OP_ADD     = 3'b010;
   localparam logic [INSTRUCTION_SIZE-1:0] OP_SUB     = 3'b011;
   localparam logic [INSTRUCTION_SIZE-1:0] NOP_OPCODE = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_HI,
      S_WAIT_LO,
      S_NEXT,
      S_ERR
   } state_t;

   function automatic logic is_legal(input logic [INSTRUCTION_SIZE-1:0] op);
      return op inside {OP_LOAD, OP_MOV, OP_ADD, OP_SUB};
   endfunction

endpackage

// File: rtl/program_buffer.sv
// rtl/program_buffer.sv - program store: synchronous write, asynchronous read, contents survive reset
module program_buffer
   import instruction_sequencer_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [WORD_SIZE-1:0]  wdata,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [WORD_SIZE-1:0]  rdata
);

   logic [WORD_SIZE-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - steps through the program buffer, handshaking each instruction on Done
module instruction_sequencer #(
   parameter int         PROG_DEPTH = 16,
   parameter int         TIMEOUT    = 8,
   parameter logic [2:0] NOP_OPCODE = instruction_sequencer_pkg::NOP_OPCODE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        prog_we,
   input  logic [3:0]  prog_addr,
   input  logic [10:0] prog_wdata,
   input  logic [4:0]  prog_len,
   input  logic        start,
   input  logic        Done,
   output logic [10:0] INSTRUCTION,
   output logic        busy,
   output logic        finished,
   output logic        error,
   output logic [3:0]  pc
);
   import instruction_sequencer_pkg::*;

   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_t            state_q, state_d;
   logic [3:0]        pc_q;
   logic [4:0]        len_q;
   logic [WD_W-1:0]   wdog_q;
   logic [10:0]       cur_word;
   logic              last;
   logic              wd_expire;

   program_buffer #(
      .DEPTH  (PROG_DEPTH),
      .ADDR_W (4)
   ) u_program_buffer (
      .clk   (clk),
      .we    (prog_we && !busy),
      .waddr (prog_addr),
      .wdata (prog_wdata),
      .raddr (pc_q),
      .rdata (cur_word)
   );

   assign last      = ({1'b0, pc_q} == (len_q - 5'd1));
   assign wd_expire = (wdog_q == WD_W'(TIMEOUT - 1));
   assign pc        = pc_q;

   // Buffer is write-locked while busy, so the async read keeps the operand stable through WAIT_LO.
   always_comb begin
      state_d     = state_q;
      INSTRUCTION = {NOP_OPCODE, 8'h00};
      busy        = 1'b0;
      error       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && (prog_len != 5'd0)) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            busy        = 1'b1;
            INSTRUCTION = cur_word;
            state_d     = is_legal(cur_word[10:8]) ? S_WAIT_HI : S_ERR;
         end
         S_WAIT_HI: begin
            busy        = 1'b1;
            INSTRUCTION = {NOP_OPCODE, cur_word[7:0]};
            if (Done)           state_d = S_WAIT_LO;
            else if (wd_expire) state_d = S_ERR;
         end
         S_WAIT_LO: begin
            busy        = 1'b1;
            INSTRUCTION = {NOP_OPCODE, cur_word[7:0]};
            if (!Done)          state_d = S_NEXT;
            else if (wd_expire) state_d = S_ERR;
         end
         S_NEXT: begin
            busy    = 1'b1;
            state_d = last ? S_IDLE : S_ISSUE;
         end
         S_ERR: begin
            error = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pc_q     <= 4'd0;
         len_q    <= 5'd0;
         wdog_q   <= '0;
         finished <= 1'b0;
      end else begin
         state_q  <= state_d;
         finished <= ((state_q == S_IDLE) && start && (prog_len == 5'd0)) ||
                     ((state_q == S_NEXT) && last);
         case (state_q)
            S_IDLE: begin
               pc_q <= 4'd0;
               if (start) len_q <= prog_len;
            end
            S_ISSUE:              wdog_q <= '0;
            S_WAIT_HI, S_WAIT_LO: wdog_q <= wdog_q + WD_W'(1);
            S_NEXT: begin
               if (!last) pc_q <= pc_q + 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - scoreboard bench: expected ISSUE/finished/error events vs observed
module tb_instruction_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = 4'd0;
   logic [10:0] prog_wdata = 11'd0;
   logic [4:0]  prog_len = 5'd0;
   logic        start = 1'b0;
   logic        Done = 1'b0;
   logic [10:0] INSTRUCTION;
   logic        busy, finished, error;
   logic [3:0]  pc;

   instruction_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_wdata  (prog_wdata),
      .prog_len    (prog_len),
      .start       (start),
      .Done        (Done),
      .INSTRUCTION (INSTRUCTION),
      .busy        (busy),
      .finished    (finished),
      .error       (error),
      .pc          (pc)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int errors = 0;

   localparam int K_ISSUE = 0;
   localparam int K_FIN   = 1;
   localparam int K_ERR   = 2;

   typedef struct {
      int          kind;
      logic [14:0] val;
      int          at;
   } ev_t;

   ev_t exp_q[$];

   function automatic void expect_ev(int kind, logic [14:0] val, int at);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.at   = at;
      exp_q.push_back(e);
   endfunction

   function automatic void check(string name, logic [14:0] act, logic [14:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void observe(int kind, logic [14:0] val);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: kind %0d val %h at cycle %0d, none expected", kind, val, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val || e.at != cyc) begin
            errors++;
            $display("FAIL event: got kind %0d val %h cycle %0d, expected kind %0d val %h cycle %0d",
                     kind, val, cyc, e.kind, e.val, e.at);
         end
      end
   endfunction

   // Monitor: any non-NOP opcode on the bus is an ISSUE.
   logic err_prev = 1'b0;
   always @(negedge clk) begin
      if (cyc > 0) begin
         if (INSTRUCTION[10:8] != 3'b111) observe(K_ISSUE, {pc, INSTRUCTION});
         if (finished)                    observe(K_FIN, 15'd0);
         if (error && !err_prev)          observe(K_ERR, 15'd0);
      end
      err_prev <= error;
   end

   // Control circuit model: Done pulses 1/2/3 cycles after ISSUE for mov/load/add-sub.
   int cnt = 0;
   bit hang = 1'b0;
   always @(negedge clk) begin
      if (Done) Done = 1'b0;
      if (cnt > 0) begin
         cnt--;
         if (cnt == 0) Done = 1'b1;
      end
      if (!hang && INSTRUCTION[10:8] != 3'b111) begin
         case (INSTRUCTION[10:8])
            3'b001:         cnt = 1;
            3'b000:         cnt = 2;
            3'b010, 3'b011: cnt = 3;
            default:        cnt = 1;
         endcase
      end
      if (reset) begin
         cnt  = 0;
         Done = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_word(input logic [3:0] a, input logic [10:0] d);
      @(negedge clk);
      prog_we = 1'b1;
      prog_addr = a;
      prog_wdata = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic begin_start(input logic [4:0] len, output int t);
      @(negedge clk);
      start = 1'b1;
      prog_len = len;
      t = cyc;
   endtask

   task automatic end_start();
      @(negedge clk);
      start = 1'b0;
   endtask

   int t;

   initial begin
      tick(3);
      check("reset_instr", {4'd0, INSTRUCTION}, 15'h0700);
      check("reset_busy", {14'd0, busy}, 15'd0);
      check("reset_pc", {11'd0, pc}, 15'd0);
      check("reset_finished", {14'd0, finished}, 15'd0);
      check("reset_error", {14'd0, error}, 15'd0);
      reset = 1'b0;

      // single mov
      write_word(4'd0, 11'h112);
      begin_start(5'd1, t);
      expect_ev(K_ISSUE, {4'd0, 11'h112}, t + 1);
      expect_ev(K_FIN, 15'd0, t + 5);
      end_start();
      tick(1);
      check("mov_wait_hi_bus", {4'd0, INSTRUCTION}, 15'h0712);
      tick(1);
      check("mov_wait_lo_bus", {4'd0, INSTRUCTION}, 15'h0712);
      tick(1);
      check("mov_next_bus", {4'd0, INSTRUCTION}, 15'h0700);
      check("mov_next_busy", {14'd0, busy}, 15'd1);
      tick(1);
      check("mov_done_busy", {14'd0, busy}, 15'd0);
      tick(2);

      // load, add, sub
      write_word(4'd0, 11'h0A5);
      write_word(4'd1, 11'h234);
      write_word(4'd2, 11'h356);
      begin_start(5'd3, t);
      expect_ev(K_ISSUE, {4'd0, 11'h0A5}, t + 1);
      expect_ev(K_ISSUE, {4'd1, 11'h234}, t + 6);
      expect_ev(K_ISSUE, {4'd2, 11'h356}, t + 12);
      expect_ev(K_FIN, 15'd0, t + 18);
      end_start();
      tick(22);

      // zero-length program
      begin_start(5'd0, t);
      expect_ev(K_FIN, 15'd0, t + 1);
      end_start();
      check("len0_busy", {14'd0, busy}, 15'd0);
      tick(3);

      // write and start together, then a write while busy
      @(negedge clk);
      prog_we = 1'b1;
      prog_addr = 4'd0;
      prog_wdata = 11'h133;
      start = 1'b1;
      prog_len = 5'd1;
      t = cyc;
      expect_ev(K_ISSUE, {4'd0, 11'h133}, t + 1);
      expect_ev(K_FIN, 15'd0, t + 5);
      @(negedge clk);
      start = 1'b0;
      prog_we = 1'b0;
      @(negedge clk);
      prog_we = 1'b1;
      prog_wdata = 11'h1FF;
      @(negedge clk);
      prog_we = 1'b0;
      tick(5);
      begin_start(5'd1, t);
      expect_ev(K_ISSUE, {4'd0, 11'h133}, t + 1);
      expect_ev(K_FIN, 15'd0, t + 5);
      end_start();
      tick(7);

      // reset during WAIT_HI of the second instruction
      begin_start(5'd3, t);
      expect_ev(K_ISSUE, {4'd0, 11'h133}, t + 1);
      expect_ev(K_ISSUE, {4'd1, 11'h234}, t + 5);
      end_start();
      tick(5);
      reset = 1'b1;
      tick(1);
      check("abort_instr", {4'd0, INSTRUCTION}, 15'h0700);
      check("abort_pc", {11'd0, pc}, 15'd0);
      check("abort_busy", {14'd0, busy}, 15'd0);
      reset = 1'b0;
      tick(6);
      begin_start(5'd3, t);
      expect_ev(K_ISSUE, {4'd0, 11'h133}, t + 1);
      expect_ev(K_ISSUE, {4'd1, 11'h234}, t + 5);
      expect_ev(K_ISSUE, {4'd2, 11'h356}, t + 11);
      expect_ev(K_FIN, 15'd0, t + 17);
      end_start();
      tick(20);

      // illegal opcode
      write_word(4'd0, 11'h512);
      begin_start(5'd1, t);
      expect_ev(K_ISSUE, {4'd0, 11'h512}, t + 1);
      expect_ev(K_ERR, 15'd0, t + 2);
      end_start();
      tick(2);
      check("illegal_error", {14'd0, error}, 15'd1);
      check("illegal_busy", {14'd0, busy}, 15'd0);
      check("illegal_bus", {4'd0, INSTRUCTION}, 15'h0700);
      begin_start(5'd1, t);
      end_start();
      tick(4);
      check("illegal_sticky", {14'd0, error}, 15'd1);
      reset = 1'b1;
      tick(1);
      check("illegal_cleared", {14'd0, error}, 15'd0);
      reset = 1'b0;

      // watchdog
      write_word(4'd0, 11'h112);
      hang = 1'b1;
      begin_start(5'd1, t);
      expect_ev(K_ISSUE, {4'd0, 11'h112}, t + 1);
      expect_ev(K_ERR, 15'd0, t + 10);
      end_start();
      tick(12);
      check("timeout_error", {14'd0, error}, 15'd1);
      reset = 1'b1;
      tick(1);
      check("timeout_cleared", {14'd0, error}, 15'd0);
      reset = 1'b0;
      hang = 1'b0;
      tick(3);

      while (exp_q.size() > 0) begin
         ev_t e;
         e = exp_q.pop_front();
         tests++;
         errors++;
         $display("FAIL missing_event: kind %0d val %h expected at cycle %0d, not seen", e.kind, e.val, e.at);
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter PROG_DEPTH, default 16, number of program-buffer entries.
REQ-002 Parameter TIMEOUT, default 8, maximum cycles spent waiting for one instruction to complete.
REQ-003 Parameter NOP_OPCODE, default 3'b111, opcode driven whenever no instruction is being issued.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high, on ports clk and reset.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 prog_we  in  1  program-buffer write enable.
REQ-008 prog_addr  in  4  program-buffer write address.
REQ-009 prog_wdata  in  11  instruction word to store: {opcode[10:8], operand[7:0]}.
REQ-010 prog_len  in  5  number of instructions to run, 0..16, sampled on start.
REQ-011 start  in  1  single-cycle run request.
REQ-012 Done  in  1  completion flag from the control circuit.
REQ-013 INSTRUCTION  out  11  instruction bus to the control circuit.
REQ-014 busy  out  1  high while a program is running.
REQ-015 finished  out  1  one-cycle pulse after the last instruction completes.
REQ-016 error  out  1  sticky fault flag.
REQ-017 pc  out  4  index of the current instruction.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT_HI, WAIT_LO, NEXT and ERR.
REQ-019 IDLE: INSTRUCTION = {NOP_OPCODE, 8'h00}; busy=0; pc=0.
- start=1 and prog_len>0 -> ISSUE, latching prog_len.
- start=1 and prog_len=0 -> finished pulse; stay in IDLE.
REQ-020 ISSUE (exactly 1 cycle): INSTRUCTION = buffer[pc]; watchdog cleared.
- opcode in 3'b000..3'b011 -> WAIT_HI.
- opcode in 3'b100..3'b111 -> ERR.
REQ-021 WAIT_HI: opcode = NOP_OPCODE, operand held at buffer[pc][7:0]; Done=1 -> WAIT_LO.
REQ-022 WAIT_LO: opcode = NOP_OPCODE, operand held; Done=0 -> NEXT.
REQ-023 Operand SHALL stay stable from ISSUE through WAIT_LO, because the control circuit decodes register selects from it during execution.
REQ-024 NEXT: opcode = NOP_OPCODE.
- pc = len-1 -> IDLE, finished=1 for one cycle.
- Otherwise pc <= pc+1 -> ISSUE.
REQ-025 Watchdog: increments each cycle in WAIT_HI/WAIT_LO; on reaching TIMEOUT -> ERR.
REQ-026 ERR: error=1, busy=0, INSTRUCTION = {NOP_OPCODE, 8'h00}; held until reset.
REQ-027 Instruction periods (ISSUE to next ISSUE): mov 4 cycles, load 5, add/sub 6.
REQ-028 Buffer write is synchronous when prog_we=1 and busy=0; writes while busy SHALL be ignored.
REQ-029 start while busy or in ERR SHALL be ignored.
REQ-030 Simultaneous start and prog_we in IDLE: the write takes effect and the run starts; the first ISSUE reads post-write contents.

Reset
REQ-031 Reset SHALL force state IDLE, pc=0, watchdog=0, busy=0, finished=0, error=0 and INSTRUCTION = {NOP_OPCODE, 8'h00}.
REQ-032 Reset mid-program SHALL abort the program with no further ISSUE; program-buffer contents SHALL NOT be reset.

Structure
REQ-033 A shared package SHALL hold opcode constants (load 000, mov 001, add 010, sub 011), NOP_OPCODE, instruction_size=3, operand_size=8 and the FSM state encoding.
REQ-034 The program buffer SHALL be sub-module program_buffer: PROG_DEPTH x 11, synchronous write, asynchronous read.

Verification
REQ-035 Program [mov r1,r2 = 0x112] with len=1 and a control-circuit model -> INSTRUCTION=0x112 for one cycle, then 0x712 until Done falls; finished pulses in cycle 4 after ISSUE; busy falls.
REQ-036 Program [load, add, sub] with len=3 -> ISSUE cycles spaced 5 and 6 cycles apart; pc steps 0,1,2; exactly one finished pulse.
REQ-037 Buffer entry 0 = 0x512 (illegal opcode) -> ERR the cycle after ISSUE; error=1 persists after further start pulses; reset clears it.
REQ-038 Done tied low after a mov ISSUE -> error=1 exactly TIMEOUT=8 cycles after entering WAIT_HI.
REQ-039 Reset asserted during WAIT_HI of the 2nd instruction -> next cycle IDLE, pc=0, NOP on the bus; a new start reruns from entry 0 with the buffer intact.
REQ-040 start with prog_len=0 -> finished pulses and no ISSUE occurs; a prog_we issued while busy leaves the stored word unchanged.
